// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the data-memory access unit.
//               It holds the memory op codes, the FSM state type, the
//               default memory depth and a helper that recognises legal
//               op codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Default word-address width of the data memory (1024 words)
    localparam int c_DATA_MEM_DEPTH = 10;

    // Memory op codes; bit 3 distinguishes stores from loads
    localparam logic [3:0] c_LD_B  = 4'h0;
    localparam logic [3:0] c_LD_H  = 4'h1;
    localparam logic [3:0] c_LD_W  = 4'h2;
    localparam logic [3:0] c_LD_BU = 4'h4;
    localparam logic [3:0] c_LD_HU = 4'h5;
    localparam logic [3:0] c_ST_B  = 4'h8;
    localparam logic [3:0] c_ST_H  = 4'h9;
    localparam logic [3:0] c_ST_W  = 4'hA;

    // Access FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // True for the eight op codes the unit implements
    function automatic logic op_is_defined(input logic [3:0] op);
        case (op)
            c_LD_B, c_LD_H, c_LD_W, c_LD_BU, c_LD_HU,
            c_ST_B, c_ST_H, c_ST_W: op_is_defined = 1'b1;
            default:                op_is_defined = 1'b0;
        endcase
    endfunction

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane handling for sub-word accesses.
//               Load path : picks the addressed byte/halfword from a memory
//                           word and sign- or zero-extends it.
//               Store path: replaces the addressed lane of a previously read
//                           word with the low bits of the store data; for
//                           st.w the store data passes through unchanged.
// Ports       : i_op          memory op code
//               i_byte_off    byte offset within the word (addr[1:0])
//               i_load_word   word read from memory for loads
//               i_merge_word  word read earlier for read-merge-write
//               i_wdata       right-aligned store data
//               o_load_data   extended load result
//               o_merge_data  word to write back to memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_merge_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection for loads
    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
        w_half = i_byte_off[1] ? i_load_word[31:16] : i_load_word[15:0];
    end

    // Extension for loads
    always_comb begin
        o_load_data = i_load_word;
        case (i_op)
            c_LD_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_LD_BU: o_load_data = {24'h000000, w_byte};
            c_LD_H:  o_load_data = {{16{w_half[15]}}, w_half};
            c_LD_HU: o_load_data = {16'h0000, w_half};
            default: o_load_data = i_load_word;
        endcase
    end

    // Lane replacement for stores
    always_comb begin
        o_merge_data = i_wdata;
        case (i_op)
            c_ST_B: begin
                o_merge_data = i_merge_word;
                case (i_byte_off)
                    2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge_data[23:16] = i_wdata[7:0];
                    default: o_merge_data[31:24] = i_wdata[7:0];
                endcase
            end
            c_ST_H: begin
                o_merge_data = i_merge_word;
                if (i_byte_off[1]) begin
                    o_merge_data[31:16] = i_wdata[15:0];
                end else begin
                    o_merge_data[15:0]  = i_wdata[15:0];
                end
            end
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Initiator-side data-memory port. Accepts one load/store at a
//               time over valid/ready, drives a single-port word memory and
//               returns one response per request. Sub-word stores use a
//               read-merge-write sequence (ACCESS reads, MERGE writes).
// Ports       : clk, rst                 clock, synchronous active-high reset
//               req_valid/req_ready      request handshake
//               req_op/addr/wdata        request contents
//               resp_valid/resp_ready    response handshake
//               resp_data/resp_err       response contents
//               mem_a/mem_d/mem_we       memory address, write data, enable
//               mem_spo                  combinational memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DEPTH = c_DATA_MEM_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic [DEPTH-1:0] mem_a,
    output logic [31:0]      mem_d,
    output logic             mem_we,
    input  logic [31:0]      mem_spo
);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_op;
    logic [DEPTH+1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_merge_buf;
    logic [31:0]        r_resp_data;
    logic               r_resp_err;

    logic               w_accept;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_req_err;
    logic               w_mem_we;
    logic [31:0]        w_load_data;
    logic [31:0]        w_merge_data;

    assign req_ready  = (r_state == S_IDLE) & ~rst;
    assign w_accept   = req_valid & req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    // Request checking, evaluated on the incoming request
    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            c_LD_H, c_LD_HU, c_ST_H: w_misaligned = req_addr[0];
            c_LD_W, c_ST_W:          w_misaligned = |req_addr[1:0];
            default:                 w_misaligned = 1'b0;
        endcase
    end

    assign w_out_of_range = |req_addr[31:DEPTH+2];
    assign w_req_err      = w_misaligned | w_out_of_range | ~op_is_defined(req_op);

    mem_lane_align u_lane_align (
        .i_op         (r_op),
        .i_byte_off   (r_addr[1:0]),
        .i_load_word  (mem_spo),
        .i_merge_word (r_merge_buf),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and write enable
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!r_op[3] || (r_op == c_ST_W)) begin
                    w_mem_we     = r_op[3];
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_MERGE;
                end
            end
            S_MERGE: begin
                w_mem_we     = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch and response/merge datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_merge_buf <= 32'h0;
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op        <= req_op;
                r_addr      <= req_addr[DEPTH+1:0];
                r_wdata     <= req_wdata;
                r_resp_data <= 32'h0;
                r_resp_err  <= w_req_err;
            end
            if (r_state == S_ACCESS) begin
                if (!r_op[3]) begin
                    r_resp_data <= w_load_data;
                end else if (r_op != c_ST_W) begin
                    r_merge_buf <= mem_spo;
                end
            end
        end
    end

    // Memory port: only driven while an access is in flight; the write
    // enable is cut by reset so no write escapes in the reset cycle.
    always_comb begin
        mem_a = '0;
        mem_d = 32'h0;
        if ((r_state == S_ACCESS) || (r_state == S_MERGE)) begin
            mem_a = r_addr[DEPTH+1:2];
            mem_d = w_merge_data;
        end
    end

    assign mem_we = w_mem_we & ~rst;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               simple synchronous-write, combinational-read word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DEPTH = 10;

    localparam logic [3:0] c_LD_B  = 4'h0;
    localparam logic [3:0] c_LD_H  = 4'h1;
    localparam logic [3:0] c_LD_W  = 4'h2;
    localparam logic [3:0] c_LD_BU = 4'h4;
    localparam logic [3:0] c_LD_HU = 4'h5;
    localparam logic [3:0] c_ST_B  = 4'h8;
    localparam logic [3:0] c_ST_H  = 4'h9;
    localparam logic [3:0] c_ST_W  = 4'hA;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic [DEPTH-1:0] mem_a;
    logic [31:0]      mem_d;
    logic             mem_we;
    logic [31:0]      mem_spo;

    logic [31:0] mem [0:(1<<DEPTH)-1];

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .mem_we     (mem_we),
        .mem_spo    (mem_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_spo = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request with resp_ready high; entered and left just after a
    // rising edge with the unit idle. lat counts cycles from the accept edge
    // to the first cycle with resp_valid; we_cnt counts mem_we cycles.
    task automatic do_req(input string tag, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic err,
                          output int lat, output int we_cnt);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat    = 0;
        we_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_we) we_cnt++;
        end while (!resp_valid && lat < 20);
        data = resp_data;
        err  = resp_err;
        @(posedge clk); #1;
    endtask

    // Run a request and compare data, error flag, latency and write count
    task automatic run(input string tag, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat, input int exp_we);
        logic [31:0] d;
        logic        e;
        int          l;
        int          w;
        do_req(tag, op, addr, wdata, d, e, l, w);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"},  {31'b0, e}, {31'b0, exp_err});
        check({tag, "_lat"},  l, exp_lat);
        check({tag, "_we"},   w, exp_we);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << DEPTH); i++) mem[i] = 32'h0;
        mem[0] = 32'h8070_F0A5;
        mem[1] = 32'h1122_3344;
        mem[4] = 32'h5566_7788;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 4'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready_rel", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_a", {22'b0, mem_a}, 32'h0);
        check("rst_mem_d", mem_d, 32'h0);
        @(posedge clk); #1;

        // Loads from word 0 = 8070_F0A5
        run("ldb",  c_LD_B,  32'h1, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 0);
        run("ldbu", c_LD_BU, 32'h1, 32'h0, 32'h0000_00F0, 1'b0, 2, 0);
        run("ldh",  c_LD_H,  32'h2, 32'h0, 32'hFFFF_8070, 1'b0, 2, 0);
        run("ldhu", c_LD_HU, 32'h2, 32'h0, 32'h0000_8070, 1'b0, 2, 0);
        run("ldb3", c_LD_B,  32'h3, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
        run("ldw",  c_LD_W,  32'h0, 32'h0, 32'h8070_F0A5, 1'b0, 2, 0);

        // Sub-word store with read-merge-write
        run("stb", c_ST_B, 32'h6, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1);
        check("stb_mem1", mem[1], 32'h11AB_3344);

        // Back-to-back sub-word stores into the same word
        run("sth2", c_ST_H, 32'h8, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1);
        run("stb2", c_ST_B, 32'h8, 32'h0000_0001, 32'h0, 1'b0, 3, 1);
        check("st2_mem2", mem[2], 32'h0000_BE01);

        // Word store then readback
        run("stw", c_ST_W, 32'hC, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1);
        check("stw_mem3", mem[3], 32'hDEAD_BEEF);
        run("ldw3", c_LD_W, 32'hC, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);

        // Error cases: no memory write, response one cycle after accept
        run("err_ldw", c_LD_W, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0);
        run("err_sth", c_ST_H, 32'h3, 32'h1234, 32'h0, 1'b1, 1, 0);
        run("err_oor", c_ST_W, 32'h1 << (DEPTH + 2), 32'h5A5A_5A5A, 32'h0, 1'b1, 1, 0);
        run("err_op",  4'h3,   32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        check("err_oor_mem0", mem[0], 32'h8070_F0A5);

        // Response back-pressure: hold resp_ready low for 5 RESP cycles
        req_valid  = 1'b1;
        req_op     = c_LD_W;
        req_addr   = 32'h0;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_data", resp_data, 32'h8070_F0A5);
            check("hold_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_rel_ready", {31'b0, req_ready}, 32'd1);
        check("hold_rel_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset during MERGE of a byte store to word 4
        req_valid = 1'b1;
        req_op    = c_ST_B;
        req_addr  = 32'h10;
        req_wdata = 32'h99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_valid", {31'b0, resp_valid}, 32'd0);
        check("mrst_data", resp_data, 32'h0);
        check("mrst_err", {31'b0, resp_err}, 32'd0);
        check("mrst_mem_a", {22'b0, mem_a}, 32'h0);
        check("mrst_mem_d", mem_d, 32'h0);
        check("mrst_mem4", mem[4], 32'h5566_7788);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        run("mrst_ld", c_LD_W, 32'h10, 32'h0, 32'h5566_7788, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side data-memory port for the core. It accepts one load or store request at a time from the execute/memory stage over a valid/ready handshake and drives the single-port word memory (`a`, `d`, `we`, `spo`). Byte and halfword accesses are built from word accesses: loads extract and extend the addressed lane, and sub-word stores use a read-merge-write sequence. It returns one response per accepted request.

## Interface
- `DEPTH`, default `` `DATA_MEM_DEPTH ``: word-address width of the memory.
- `clk` in 1: clock; everything samples on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the unit can accept a request.
- `req_op` in 4: memory op code (see Structure).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: a response is present.
- `resp_ready` in 1: the consumer accepts the response.
- `resp_data` out 32: load result, already extended; 0 for stores.
- `resp_err` out 1: the request was misaligned or out of range; no memory access was made.
- `mem_a` out DEPTH: word address to the memory.
- `mem_d` out 32: write data to the memory.
- `mem_we` out 1: write enable to the memory.
- `mem_spo` in 32: combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
- `req_ready` = (state == IDLE) & !`rst`.
- A request is accepted when `req_valid` & `req_ready`. On acceptance the unit latches op, addr and wdata, and computes:
  - error = misaligned (half: addr[0] ≠ 0; word: addr[1:0] ≠ 0), or addr[31:DEPTH+2] ≠ 0, or an undefined op.
  - If error: go to RESP with `resp_err`=1 and `resp_data`=0.
  - Otherwise: go to ACCESS.
- ACCESS: `mem_a` = addr[DEPTH+1:2].
  - Load: select lane by addr[1:0] (byte) or addr[1] (half); sign- or zero-extend; register into `resp_data`; go to RESP.
  - st.w: `mem_we`=1, `mem_d`=wdata; go to RESP.
  - st.b / st.h: register `mem_spo` into the merge buffer; go to MERGE.
- MERGE: `mem_a` unchanged; `mem_we`=1; `mem_d` = merge buffer with the addressed lane replaced by wdata[7:0] or wdata[15:0]; go to RESP.
- RESP: `resp_valid`=1 and `resp_data`/`resp_err` are held stable until `resp_ready`; then go to IDLE.
- `resp_valid` and `resp_ready` both high in RESP → IDLE on the next edge. A new request can be accepted no earlier than the cycle after that.
- `mem_we` is asserted only in ACCESS (st.w) or MERGE, and is forced low while `rst`=1.
- The memory may buffer writes by one cycle and forward them. The unit relies on `mem_spo` reflecting the immediately preceding write to the same word.

## Timing
- Reset values: state IDLE, `resp_valid` 0, `resp_data` 0, `resp_err` 0, `mem_we` 0, `mem_a` 0, `mem_d` 0. `req_ready` goes to 1 in the first cycle after reset is released.
- Latency from the accept edge to the first `resp_valid` cycle:
  - Load or st.w: 2 cycles.
  - st.b / st.h: 3 cycles.
  - Error: 1 cycle.
- Throughput with `resp_ready` held high: one load per 3 cycles; one sub-word store per 4 cycles.
- `rst` asserted in any state: at the next edge the unit is in IDLE with all outputs at reset values. No write is issued in the reset cycle. An in-flight response is discarded.
- `mem_a`/`mem_d`/`mem_we` are combinational from state plus registers; `mem_spo` is sampled only in ACCESS.

## Structure
- Op codes are `` `define ``s in `configs.vh``:
  - LD_B=4'h0, LD_H=4'h1, LD_W=4'h2, LD_BU=4'h4, LD_HU=4'h5.
  - ST_B=4'h8, ST_H=4'h9, ST_W=4'hA.
  - op[3] = store.
- FSM state encodings are also `` `define ``s in `configs.vh``.
- One combinational sub-module, `mem_lane_align`, contains both load lane extraction/extension and store lane merge. The FSM stays in `mem_access_unit`.

## Test plan
- Memory word 0 = 32'h8070_F0A5.
  - ld.b addr 0x1 → `resp_data` 32'hFFFF_FFF0.
  - ld.bu addr 0x1 → 32'h0000_00F0.
  - ld.h addr 0x2 → 32'hFFFF_8070.
  - ld.w addr 0x0 → 32'h8070_F0A5, with `resp_valid` 2 cycles after accept.
- Word 1 = 32'h1122_3344; st.b addr 0x6 with data 32'hFFFF_FFAB → word 1 = 32'h11AB_3344. `mem_we` high for exactly 1 cycle (MERGE); response 3 cycles after accept.
- Back-to-back st.h addr 0x8 data 16'hBEEF, then st.b addr 0x8 data 8'h01, starting from word 2 = 0 → word 2 = 32'h0000_BE01.
- Misaligned and out-of-range requests → `resp_err`=1 one cycle after accept, and `mem_we` never asserted:
  - ld.w addr 0x2.
  - st.h addr 0x3.
  - Address with bit DEPTH+2 set.
- Hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid` and `resp_data` stable and `req_ready`=0 throughout. Release → IDLE next cycle.
- Assert `rst` during MERGE of st.b → `mem_we`=0 in that cycle, target word unchanged, all outputs at reset values the next cycle.
